// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for dmem_arbiter; one instance per requester.
// The requester drives req/we/addr/wdata; the arbiter returns ack/rdata/err.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input ack, rdata, err);
  modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the single-port data memory.
// Each transaction runs IDLE -> ACCESS -> RESP; bad addresses never reach the memory.
module dmem_arbiter #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [29:0]       idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              err0_q, err0_d, err1_q, err1_d;

  logic              sel;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    // On a tie the requester not served last wins; otherwise whoever is asking.
    sel      = (m0.req && m1.req) ? ~last_grant_q : m1.req;
    sel_addr = sel ? m1.addr : m0.addr;
    rd_val   = (!we_q && !err_q) ? mem_read_data : '0;

    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    err_d        = err_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    err0_d       = err0_q;
    err1_d       = err1_q;

    unique case (state_q)
      StIdle: begin
        if (m0.req || m1.req) begin
          gnt_d        = sel;
          last_grant_d = sel;
          we_d         = sel ? m1.we : m0.we;
          wdata_d      = sel ? m1.wdata : m0.wdata;
          idx_d        = sel_addr[31:2];
          err_d        = (sel_addr[1:0] != 2'b00) ||
                         ({2'b00, sel_addr[31:2]} >= DEPTH_WORDS);
          state_d      = StAccess;
        end
      end
      StAccess: begin
        if (gnt_q) begin
          rdata1_d = rd_val;
          err1_d   = err_q;
        end else begin
          rdata0_d = rd_val;
          err0_d   = err_q;
        end
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      err_q        <= err_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  assign mem_address    = {2'b00, idx_q};
  assign mem_write_data = wdata_q;
  assign mem_MemRead    = (state_q == StAccess) && !we_q && !err_q;
  // Reset during ACCESS must suppress the write that would commit on this edge.
  assign mem_MemWrite   = (state_q == StAccess) && we_q && !err_q && !reset;

  assign m0.ack   = (state_q == StResp) && !gnt_q;
  assign m1.ack   = (state_q == StResp) && gnt_q;
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;
  assign m0.err   = err0_q;
  assign m1.err   = err1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter against a word-array reference model.
// A behavioural 32-word memory sits on the DUT's memory port.
module tb_dmem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned ND = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DW)) m0_bus ();
  dmem_arbiter_if #(.DATA_W(DW)) m1_bus ();

  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_read_data;

  dmem_arbiter #(.DATA_W(DW), .DEPTH_WORDS(ND)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_MemRead    (mem_MemRead),
    .mem_MemWrite   (mem_MemWrite),
    .mem_read_data  (mem_read_data)
  );

  logic [31:0] mem [ND];
  always @(posedge clk) if (mem_MemWrite) mem[mem_address[4:0]] <= mem_write_data;
  assign mem_read_data = (mem_address < ND) ? mem[mem_address[4:0]] : 32'h0;

  // Reference state: memory contents and the rdata/err each requester should be holding.
  logic [31:0] ref_mem [ND];
  logic [31:0] hold_rdata [2];
  logic        hold_err [2];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    if (p == 0) begin
      m0_bus.req = req; m0_bus.we = we; m0_bus.addr = a; m0_bus.wdata = d;
    end else begin
      m1_bus.req = req; m1_bus.we = we; m1_bus.addr = a; m1_bus.wdata = d;
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? m0_bus.ack : m1_bus.ack;
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? m0_bus.rdata : m1_bus.rdata;
  endfunction
  function automatic logic err_of(input int p);
    return (p == 0) ? m0_bus.err : m1_bus.err;
  endfunction
  function automatic logic addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= ND);
  endfunction

  // Single uncontended transaction, started at a negedge with the arbiter idle.
  task automatic txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic        bad;
    logic [31:0] exp_rd;
    bad    = addr_bad(a);
    exp_rd = (!we && !bad) ? ref_mem[a[6:2]] : 32'h0;
    drive(p, 1'b1, we, a, d);
    @(negedge clk);
    check($sformatf("m%0d MemRead", p), 32'(mem_MemRead), 32'(!we && !bad));
    check($sformatf("m%0d MemWrite", p), 32'(mem_MemWrite), 32'(we && !bad));
    if (!bad) check($sformatf("m%0d mem_address", p), mem_address, a / 4);
    if (we && !bad) check($sformatf("m%0d mem_write_data", p), mem_write_data, d);
    @(negedge clk);
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
    check($sformatf("m%0d ack", p), 32'(ack_of(p)), 32'd1);
    check($sformatf("m%0d other ack", p), 32'(ack_of(1 - p)), 32'd0);
    check($sformatf("m%0d rdata a=%08h", p, a), rdata_of(p), exp_rd);
    check($sformatf("m%0d err a=%08h", p, a), 32'(err_of(p)), 32'(bad));
    check($sformatf("m%0d other rdata held", p), rdata_of(1 - p), hold_rdata[1 - p]);
    check($sformatf("m%0d mem ctl idle in RESP", p), 32'({mem_MemRead, mem_MemWrite}), 32'd0);
    hold_rdata[p] = exp_rd;
    hold_err[p]   = bad;
    if (we && !bad) ref_mem[a[6:2]] = d;
    @(negedge clk);
  endtask

  initial begin
    int          exp_p, got, last_c, raised, m0_after;
    logic        m1_done, done;
    int          p, kind;
    logic        we;
    logic [31:0] a;

    for (int i = 0; i < ND; i++) begin
      mem[i]     = 32'h100 + i;
      ref_mem[i] = 32'h100 + i;
    end
    mem[0] = 32'h5; mem[1] = 32'h2; mem[2] = 32'h3;
    ref_mem[0] = 32'h5; ref_mem[1] = 32'h2; ref_mem[2] = 32'h3;
    hold_rdata[0] = 32'h0; hold_rdata[1] = 32'h0;
    hold_err[0] = 1'b0; hold_err[1] = 1'b0;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("reset acks", 32'({m1_bus.ack, m0_bus.ack}), 32'd0);
    check("reset rdata0", m0_bus.rdata, 32'h0);
    check("reset rdata1", m1_bus.rdata, 32'h0);
    check("reset errs", 32'({m1_bus.err, m0_bus.err}), 32'd0);
    check("reset mem ctl", 32'({mem_MemRead, mem_MemWrite}), 32'd0);
    check("reset mem_address", mem_address, 32'h0);
    reset = 1'b0;

    // Simultaneous requests out of reset: m0 first, then strict alternation.
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h4, 32'h0);
    exp_p = 0; got = 0; last_c = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (m0_bus.ack || m1_bus.ack) begin
        check($sformatf("tie ack #%0d port", got), 32'({m1_bus.ack, m0_bus.ack}),
              (exp_p == 1) ? 32'd2 : 32'd1);
        check($sformatf("tie ack #%0d rdata", got), rdata_of(exp_p), ref_mem[exp_p]);
        if (got == 0) check("tie first ack latency", c, 1);
        else check($sformatf("tie ack #%0d spacing", got), c - last_c, 3);
        hold_rdata[exp_p] = ref_mem[exp_p];
        last_c = c;
        got++;
        exp_p = 1 - exp_p;
      end
    end
    check("tie acks seen", got, 4);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h10, 32'h0);
    txn(1, 1'b1, 32'h6, 32'hCAFEF00D);
    txn(1, 1'b0, 32'h4, 32'h0);
    txn(0, 1'b0, 32'h80, 32'h0);

    // Reset landing in ACCESS aborts the write and its ack.
    drive(0, 1'b1, 1'b1, 32'h8, 32'h1234);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort MemWrite suppressed", 32'(mem_MemWrite), 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    hold_rdata[0] = 32'h0; hold_rdata[1] = 32'h0;
    check("abort rdata0 cleared", m0_bus.rdata, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort no ack", 32'({m1_bus.ack, m0_bus.ack}), 32'd0);
    end
    txn(0, 1'b0, 32'h8, 32'h0);

    // m0 streams continuously; m1 joins mid-stream and must be served promptly.
    drive(0, 1'b1, 1'b0, 32'hC, 32'h0);
    raised = -1; m1_done = 1'b0; m0_after = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (m1_bus.ack) begin
        check("stream m1 latency ok", 32'((c - raised) <= 6), 32'd1);
        check("stream m1 rdata", m1_bus.rdata, ref_mem[5]);
        hold_rdata[1] = ref_mem[5];
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        m1_done = 1'b1;
      end
      if (m0_bus.ack) begin
        check("stream m0 rdata", m0_bus.rdata, ref_mem[3]);
        hold_rdata[0] = ref_mem[3];
        if (m1_done) m0_after++;
        if (m0_after == 2) begin
          drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
          done = 1'b1;
        end
      end
      if (c == 7) begin
        drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
        raised = c;
      end
    end
    check("stream m1 served", 32'(m1_done), 32'd1);
    check("stream m0 resumed", m0_after, 2);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      p    = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 5));
      if (kind == 0) a = $urandom_range(0, 31) * 4 + $urandom_range(1, 3);
      else if (kind == 1) a = ($urandom & 32'hFFFF_FFFC) | 32'h80;
      else a = $urandom_range(0, 31) * 4;
      txn(p, we, a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
